processor_datapath: RTL and testbench
=====================================

# processor_datapath

Execution datapath for the 10-bit processor. It consumes the per-timestep control word from the processor controller and drives the shared bus, register file, ALU operand registers A and G, the instruction register and the 2-bit timestep counter. It returns `IR` and `timestep` to the controller, closing the decode/execute loop.

## Interface
- `WIDTH`, 10: datapath, bus and IR width. It is fixed by the instruction format, so only 10 is supported.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `data`  in  WIDTH  external data (instructions and LOAD operands)
- `IMM`  in  WIDTH  immediate from controller; may be z when unused
- `Rin`  in  2  register write address
- `Rout`  in  2  register read address
- `ENW`  in  1  write bus to `R[Rin]`
- `ENR`  in  1  drive `R[Rout]` onto bus
- `Ain`  in  1  A ← bus
- `Gin`  in  1  G ← bus
- `Gout`  in  1  drive ALU result onto bus
- `ALUcont`  in  4  ALU op; may be z when `Gout`=0
- `Ext`  in  1  drive `data` onto bus
- `IRin`  in  1  IR ← bus
- `Clr`  in  1  timestep ← 0 at next edge
- `IR`  out  WIDTH  instruction register
- `timestep`  out  2  timestep counter
- `bus`  out  WIDTH  current shared-bus value (combinational)
- `done`  out  1  registered; high for the cycle after any cycle with `Clr`=1
- `bus_conflict`  out  1  sticky; set when more than one of `Ext`/`ENR`/`Gout` is high in a cycle

## Operation
- Bus source priority is `Ext` > `ENR` > `Gout` > `IMM`. With no enable high, the bus carries `IMM`. An unknown `IMM` makes `bus` a don't-care.
- The register file is R0–R3, each WIDTH bits. Reads are combinational. A write of `R[Rin]` ← bus occurs when `ENW`=1.
- Read-during-write: the bus carries the old value, and the new value is visible the next cycle. A COPY with Rx==Ry leaves the register unchanged.
- A, G and IR load from the bus on `Ain`, `Gin` and `IRin`. Several destinations may load in the same cycle.
- The ALU is combinational on (A, G). All results are truncated mod 2^WIDTH. The shift amount is `G[3:0]`, and any amount ≥10 gives 0, or sign-fill for SRA.
  - 0010 ADD: A+G
  - 0011 SUB: A−G
  - 0100 AND
  - 0101 OR
  - 0110 XOR
  - 0111 NOT: ~A
  - 1000 SLL: A<<G
  - 1001 SRL: A>>G, logical
  - 1010 SRA: A>>>G, arithmetic
  - 1011 SLT: 1 if signed A<G, else 0
- Any other `ALUcont` value (including X/z) with `Gout`=1 gives result 0.
- Instruction flows that must work end to end:
  - ALU op: ts1 A←Rx; ts2 G←Ry; ts3 Rx←ALU.
  - Immediate op: ts1 G←Rx; ts2 A←IMM, with no bus enable; ts3 Rx←A+G.
  - LOAD: ts1 Rx←data.
  - COPY: ts1 Rx←Ry.
- `bus_conflict` is cleared only by reset.

## Timing
- Reset (`rst_n`=0 at an edge) zeroes R0–R3, A, G, IR, `timestep`, `done` and `bus_conflict`. Reset overrides every enable in the same cycle.
- A reset mid-instruction abandons the instruction. The next cycle is ts0 with no partial writes retained.
- The timestep counter evaluates in this order:
  - reset: 00
  - else `Clr`: 00
  - else +1, wrapping 11→00 with no flag.
- All register loads (R, A, G, IR) take effect at the edge ending the cycle in which their enable is high. They are visible on outputs and the bus in the following cycle.
- Latency: an ALU instruction is 4 cycles (ts0–ts3), immediate is 4, LOAD/COPY is 2. `done` asserts in the cycle after the final timestep.
- `bus` is purely combinational from current state and inputs, with no added latency.

## Structure
- Shared package `processor_pkg` holds:
  - `WIDTH`
  - opcode constants LOAD=0000 and COPY=0001
  - ALU op constants 0010–1011 as an enum `alu_op_t`
  - instruction field positions: Rx=[9:8], Ry=[7:6], op=[5:2], class=[1:0]
- Sub-module `processor_alu`: combinational, with inputs (A, G, `ALUcont`) and output result. The controller and testbench reuse the same constants.
- Top level holds the bus mux, register file, A/G/IR registers, counter and flags.

## Test plan
- Reset: preload R1=0x0AA, then hold `rst_n`=0 for one edge → R0–R3=0, IR=0, `timestep`=0, `bus_conflict`=0.
- LOAD: ts0 `IRin`/`Ext` with `data`=0x100 → IR=0x100. ts1 `Ext`, `data`=0x155, `ENW`, `Rin`=1, `Clr` → R1=0x155, `timestep`=0, `done`=1 the next cycle.
- ALU ADD then SUB: R0=5, R1=7, full ts1–ts3 sequence with `ALUcont`=0010, `Rin`=0 → R0=12. Repeat with 0011, A=3, G=5 → 0x3FE.
- Immediate: R2=20, ts1 `ENR`/`Gin` `Rout`=2, ts2 `Ain` with `IMM`=0x3FB, ts3 ADD → R2=15. The wrap is mod 1024.
- Shifts/SLT: A=0x200, G=1, SRA → 0x300 and SRL → 0x100. G=12 with SLL → 0. A=0x3FF, G=0, SLT → 1.
- Boundaries:
  - `Ext`+`ENR` in the same cycle → bus=`data` and `bus_conflict`=1, which persists until reset.
  - Four cycles without `Clr` → `timestep` goes 00,01,10,11,00.
  - COPY R3←R3 → R3 unchanged.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared constants and types for the 10-bit processor: widths, opcodes, ALU ops and instruction fields.
package processor_pkg;

  localparam int unsigned WIDTH   = 10;
  localparam int unsigned NREGS   = 4;
  localparam int unsigned SHAMT_W = 4;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_COPY = 4'b0001;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0011,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_NOT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_SLT = 4'b1011
  } alu_op_t;

  // Instruction field positions within IR
  localparam int unsigned RX_MSB  = 9;
  localparam int unsigned RX_LSB  = 8;
  localparam int unsigned RY_MSB  = 7;
  localparam int unsigned RY_LSB  = 6;
  localparam int unsigned OP_MSB  = 5;
  localparam int unsigned OP_LSB  = 2;
  localparam int unsigned CLS_MSB = 1;
  localparam int unsigned CLS_LSB = 0;

  typedef struct packed {
    logic [1:0] rx;
    logic [1:0] ry;
    logic [3:0] op;
    logic [1:0] cls;
  } instr_t;

endpackage

// File: rtl/processor_alu.sv
// Combinational ALU on operands A and G; unknown or unused op codes produce zero.
module processor_alu
  import processor_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] g,
  input  logic [3:0]       alucont,
  output logic [WIDTH-1:0] result
);

  logic [SHAMT_W-1:0] shamt;
  logic               big_shift;

  assign shamt     = g[SHAMT_W-1:0];
  assign big_shift = (32'(shamt) >= WIDTH);

  // Shifts of WIDTH or more saturate to zero, or to sign-fill for SRA
  always_comb begin
    result = '0;
    case (alucont)
      ALU_ADD: result = a + g;
      ALU_SUB: result = a - g;
      ALU_AND: result = a & g;
      ALU_OR:  result = a | g;
      ALU_XOR: result = a ^ g;
      ALU_NOT: result = ~a;
      ALU_SLL: result = big_shift ? '0 : (a << shamt);
      ALU_SRL: result = big_shift ? '0 : (a >> shamt);
      ALU_SRA: result = big_shift ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> shamt);
      ALU_SLT: result = WIDTH'($signed(a) < $signed(g));
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/processor_datapath.sv
// Execution datapath: shared bus, register file R0-R3, A/G/IR registers,
// timestep counter and done/bus_conflict flags driven by the controller's control word.
module processor_datapath
  import processor_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] IMM,
  input  logic [1:0]       Rin,
  input  logic [1:0]       Rout,
  input  logic             ENW,
  input  logic             ENR,
  input  logic             Ain,
  input  logic             Gin,
  input  logic             Gout,
  input  logic [3:0]       ALUcont,
  input  logic             Ext,
  input  logic             IRin,
  input  logic             Clr,
  output logic [WIDTH-1:0] IR,
  output logic [1:0]       timestep,
  output logic [WIDTH-1:0] bus,
  output logic             done,
  output logic             bus_conflict
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] alu_result;
  logic             multi_drive;

  processor_alu u_alu (
    .a       (a_q),
    .g       (g_q),
    .alucont (ALUcont),
    .result  (alu_result)
  );

  // Bus source priority: Ext > ENR > Gout > IMM
  always_comb begin
    bus = IMM;
    if (Ext)       bus = data;
    else if (ENR)  bus = regs[Rout];
    else if (Gout) bus = alu_result;
  end

  assign multi_drive = (Ext & ENR) | (Ext & Gout) | (ENR & Gout);

  // Reads see pre-edge contents, so a same-register write-back leaves the old value on the bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      a_q          <= '0;
      g_q          <= '0;
      IR           <= '0;
      timestep     <= 2'b00;
      done         <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      if (ENW)  regs[Rin] <= bus;
      if (Ain)  a_q       <= bus;
      if (Gin)  g_q       <= bus;
      if (IRin) IR        <= bus;
      timestep <= Clr ? 2'b00 : timestep + 2'd1;
      done     <= Clr;
      if (multi_drive) bus_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_processor_datapath.sv
// Directed and randomized checks of processor_datapath against an arithmetic reference model.
module tb_processor_datapath;
  import processor_pkg::*;

  typedef struct {
    logic       rst_n;
    logic [9:0] data;
    logic [9:0] imm;
    logic [1:0] rin;
    logic [1:0] rout;
    logic       enw, enr, ain, gin, gout, ext, irin, clr;
    logic [3:0] aluc;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] data, IMM;
  logic [1:0] Rin, Rout;
  logic       ENW, ENR, Ain, Gin, Gout, Ext, IRin, Clr;
  logic [3:0] ALUcont;
  logic [9:0] IR, bus;
  logic [1:0] timestep;
  logic       done, bus_conflict;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int   m_r [4];
  int   m_a, m_g, m_ir, m_ts;
  logic m_done, m_conf;

  processor_datapath dut (
    .clk(clk), .rst_n(rst_n), .data(data), .IMM(IMM), .Rin(Rin), .Rout(Rout),
    .ENW(ENW), .ENR(ENR), .Ain(Ain), .Gin(Gin), .Gout(Gout), .ALUcont(ALUcont),
    .Ext(Ext), .IRin(IRin), .Clr(Clr), .IR(IR), .timestep(timestep), .bus(bus),
    .done(done), .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 512) ? v - 1024 : v;
  endfunction

  function automatic int m_alu(input int a, input int g, input logic [3:0] op);
    int sa  = to_signed(a);
    int sg  = to_signed(g);
    int amt = g % 16;
    int p   = 2 ** amt;
    int res;
    case (op)
      4'd2:    res = a + g;
      4'd3:    res = a - g;
      4'd4:    res = int'(10'(a) & 10'(g));
      4'd5:    res = int'(10'(a) | 10'(g));
      4'd6:    res = int'(10'(a) ^ 10'(g));
      4'd7:    res = 1023 - a;
      4'd8:    res = (amt >= 10) ? 0 : a * p;
      4'd9:    res = a / p;
      4'd10:   res = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
      4'd11:   res = (sa < sg) ? 1 : 0;
      default: res = 0;
    endcase
    return ((res % 1024) + 1024) % 1024;
  endfunction

  function automatic int m_bus(input ctl_t c);
    if (c.ext)  return int'(c.data);
    if (c.enr)  return m_r[c.rout];
    if (c.gout) return m_alu(m_a, m_g, c.aluc);
    return int'(c.imm);
  endfunction

  function automatic void m_update(input ctl_t c, input int b);
    if (!c.rst_n) begin
      foreach (m_r[i]) m_r[i] = 0;
      m_a = 0; m_g = 0; m_ir = 0; m_ts = 0; m_done = 1'b0; m_conf = 1'b0;
    end else begin
      if (c.enw)  m_r[c.rin] = b;
      if (c.ain)  m_a = b;
      if (c.gin)  m_g = b;
      if (c.irin) m_ir = b;
      m_ts   = c.clr ? 0 : (m_ts + 1) % 4;
      m_done = c.clr;
      if (int'(c.ext) + int'(c.enr) + int'(c.gout) > 1) m_conf = 1'b1;
    end
  endfunction

  function automatic ctl_t idle();
    ctl_t c;
    c.rst_n = 1'b1; c.data = '0; c.imm = '0; c.rin = '0; c.rout = '0;
    c.enw = 0; c.enr = 0; c.ain = 0; c.gin = 0; c.gout = 0; c.ext = 0; c.irin = 0; c.clr = 0;
    c.aluc = '0;
    return c;
  endfunction

  // One cycle: drive, check bus, clock, check registered outputs
  task automatic run(input ctl_t c, output logic [9:0] b);
    int eb;
    rst_n = c.rst_n; data = c.data; IMM = c.imm; Rin = c.rin; Rout = c.rout;
    ENW = c.enw; ENR = c.enr; Ain = c.ain; Gin = c.gin; Gout = c.gout;
    Ext = c.ext; IRin = c.irin; Clr = c.clr; ALUcont = c.aluc;
    #1;
    eb = m_bus(c);
    b  = bus;
    chk("bus", 32'(bus), 32'(eb));
    @(posedge clk);
    m_update(c, eb);
    #1;
    chk("ir", 32'(IR), 32'(m_ir));
    chk("timestep", 32'(timestep), 32'(m_ts));
    chk("done", 32'(done), 32'(m_done));
    chk("bus_conflict", 32'(bus_conflict), 32'(m_conf));
  endtask

  task automatic rd(input logic [1:0] k, output logic [9:0] v);
    ctl_t c = idle();
    c.enr = 1; c.rout = k;
    run(c, v);
  endtask

  task automatic load(input logic [1:0] k, input logic [9:0] v);
    ctl_t c = idle();
    logic [9:0] b;
    c.ext = 1; c.data = v; c.enw = 1; c.rin = k; c.clr = 1;
    run(c, b);
  endtask

  task automatic set_ag(input logic [9:0] av, input logic [9:0] gv);
    ctl_t c = idle();
    logic [9:0] b;
    c.ext = 1; c.data = av; c.ain = 1; run(c, b);
    c = idle(); c.ext = 1; c.data = gv; c.gin = 1; run(c, b);
  endtask

  task automatic alu_instr(input logic [1:0] rx, input logic [1:0] ry, input logic [3:0] op);
    ctl_t c = idle();
    logic [9:0] b;
    run(c, b);
    c = idle(); c.enr = 1; c.rout = rx; c.ain = 1; run(c, b);
    c = idle(); c.enr = 1; c.rout = ry; c.gin = 1; run(c, b);
    c = idle(); c.gout = 1; c.aluc = op; c.enw = 1; c.rin = rx; c.clr = 1; run(c, b);
  endtask

  task automatic peek_alu(input logic [3:0] op, output logic [9:0] v);
    ctl_t c = idle();
    c.gout = 1; c.aluc = op;
    run(c, v);
  endtask

  initial begin
    ctl_t c;
    logic [9:0] v;

    c = idle(); c.rst_n = 0; run(c, v);

    // Reset clears a preloaded register and all flags
    load(2'd1, 10'h0AA);
    c = idle(); c.rst_n = 0; c.ext = 1; c.data = 10'h3FF; c.enw = 1; c.rin = 1; c.ain = 1;
    run(c, v);
    chk("rst_ir", 32'(IR), 32'h0);
    chk("rst_ts", 32'(timestep), 32'h0);
    chk("rst_conf", 32'(bus_conflict), 32'h0);
    for (int k = 0; k < 4; k++) begin
      rd(2'(k), v);
      chk("rst_reg", 32'(v), 32'h0);
    end

    // LOAD
    c = idle(); c.rst_n = 0; run(c, v);
    c = idle(); c.irin = 1; c.ext = 1; c.data = 10'h100; run(c, v);
    chk("load_ir", 32'(IR), 32'h100);
    c = idle(); c.ext = 1; c.data = 10'h155; c.enw = 1; c.rin = 1; c.clr = 1; run(c, v);
    chk("load_ts", 32'(timestep), 32'h0);
    chk("load_done", 32'(done), 32'h1);
    rd(2'd1, v);
    chk("load_r1", 32'(v), 32'h155);

    // ADD then SUB
    load(2'd0, 10'd5); load(2'd1, 10'd7);
    alu_instr(2'd0, 2'd1, 4'b0010);
    chk("add_done", 32'(done), 32'h1);
    rd(2'd0, v); chk("add_r0", 32'(v), 32'd12);
    load(2'd0, 10'd3); load(2'd1, 10'd5);
    alu_instr(2'd0, 2'd1, 4'b0011);
    rd(2'd0, v); chk("sub_r0", 32'(v), 32'h3FE);

    // Immediate add with wrap
    load(2'd2, 10'd20);
    c = idle(); c.enr = 1; c.rout = 2; c.gin = 1; run(c, v);
    c = idle(); c.ain = 1; c.imm = 10'h3FB; run(c, v);
    chk("imm_bus", 32'(v), 32'h3FB);
    c = idle(); c.gout = 1; c.aluc = 4'b0010; c.enw = 1; c.rin = 2; c.clr = 1; run(c, v);
    rd(2'd2, v); chk("imm_r2", 32'(v), 32'd15);

    // Shifts, SLT, invalid op
    set_ag(10'h200, 10'd1);
    peek_alu(4'b1010, v); chk("sra", 32'(v), 32'h300);
    peek_alu(4'b1001, v); chk("srl", 32'(v), 32'h100);
    set_ag(10'h200, 10'd12);
    peek_alu(4'b1000, v); chk("sll_big", 32'(v), 32'h0);
    peek_alu(4'b1010, v); chk("sra_big", 32'(v), 32'h3FF);
    set_ag(10'h3FF, 10'd0);
    peek_alu(4'b1011, v); chk("slt", 32'(v), 32'h1);
    peek_alu(4'bxxxx, v); chk("alu_x", 32'(v), 32'h0);
    peek_alu(4'b1111, v); chk("alu_bad", 32'(v), 32'h0);

    // COPY R3 <- R3
    load(2'd3, 10'h1C7);
    c = idle(); c.enr = 1; c.rout = 3; c.enw = 1; c.rin = 3; c.clr = 1; run(c, v);
    rd(2'd3, v); chk("copy_r3", 32'(v), 32'h1C7);

    // Timestep wrap from reset
    c = idle(); c.rst_n = 0; run(c, v);
    for (int k = 1; k <= 4; k++) begin
      c = idle(); run(c, v);
      chk("ts_seq", 32'(timestep), 32'(k % 4));
    end

    // Bus conflict priority and stickiness
    c = idle(); c.ext = 1; c.enr = 1; c.data = 10'h2AB; run(c, v);
    chk("conf_bus", 32'(v), 32'h2AB);
    chk("conf_set", 32'(bus_conflict), 32'h1);
    for (int k = 0; k < 3; k++) begin c = idle(); c.clr = 1; run(c, v); end
    chk("conf_sticky", 32'(bus_conflict), 32'h1);
    c = idle(); c.rst_n = 0; run(c, v);
    chk("conf_clr", 32'(bus_conflict), 32'h0);

    // Randomized control words
    for (int n = 0; n < 400; n++) begin
      c.rst_n = ($urandom_range(0, 39) != 0);
      c.data  = 10'($urandom);
      c.imm   = 10'($urandom);
      c.rin   = 2'($urandom);
      c.rout  = 2'($urandom);
      c.enw   = 1'($urandom);
      c.ain   = 1'($urandom);
      c.gin   = 1'($urandom);
      c.irin  = ($urandom_range(0, 3) == 0);
      c.clr   = ($urandom_range(0, 3) == 0);
      c.ext   = ($urandom_range(0, 4) == 0);
      c.enr   = ($urandom_range(0, 2) == 0);
      c.gout  = ($urandom_range(0, 2) == 0);
      c.aluc  = 4'($urandom);
      run(c, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
